// File: rtl/cascade_inta_responder.sv
// INTA-cycle responder for an 8259-compatible PIC: tracks the two-pulse acknowledge,
// decides vector ownership (single/master/slave) and emits ISR set / auto-EOI strobes.
module cascade_inta_responder #(
    parameter int unsigned GAP_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       INTA_n,
    input  logic [2:0] CAS,
    input  logic       SP,
    input  logic       SNGL,
    input  logic [7:0] ICW3,
    input  logic [4:0] ICW2_T,
    input  logic       AEOI,
    input  logic [2:0] Interrupt_Location,
    input  logic       interruptExists,
    output logic [7:0] Data_Out,
    output logic       Data_Out_Enable,
    output logic       IS_Set,
    output logic [2:0] IS_Level,
    output logic       Auto_EOI,
    output logic       Cycle_Active,
    output logic       Protocol_Error
);

    localparam int unsigned CW = (GAP_TIMEOUT > 2) ? $clog2(GAP_TIMEOUT) : 1;
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_P1,
        S_GAP,
        S_P2
    } state_t;

    state_t        state, state_n;
    logic          inta_q;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    lvl, lvl_n;
    logic          valid, valid_n;
    logic          own, own_n;
    logic [7:0]    icw3_q, icw3_n;

    logic [7:0]    dout_n;
    logic          doe_n;
    logic          is_set_n;
    logic [2:0]    is_level_n;
    logic          aeoi_n;
    logic          active_n;
    logic          perr_n;

    logic          fall, rise;

    assign fall = inta_q & ~INTA_n;
    assign rise = ~inta_q & INTA_n;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        lvl_n      = lvl;
        valid_n    = valid;
        own_n      = own;
        icw3_n     = icw3_q;
        dout_n     = Data_Out;
        doe_n      = Data_Out_Enable;
        is_set_n   = 1'b0;
        is_level_n = IS_Level;
        aeoi_n     = 1'b0;
        perr_n     = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (fall) begin
                    state_n    = S_P1;
                    lvl_n      = interruptExists ? Interrupt_Location : 3'b111;
                    valid_n    = interruptExists;
                    icw3_n     = ICW3;
                    is_level_n = interruptExists ? Interrupt_Location : 3'b111;
                end
            end
            S_P1: begin
                if (rise) begin
                    state_n  = S_GAP;
                    cnt_n    = '0;
                    is_set_n = valid;
                    // ICW3 is taken from the copy captured at the first fall
                    if (SNGL)
                        own_n = 1'b1;
                    else if (SP)
                        own_n = ~icw3_q[lvl];
                    else
                        own_n = (CAS == icw3_q[2:0]);
                end
            end
            S_GAP: begin
                if (fall) begin
                    state_n = S_P2;
                    doe_n   = own;
                    dout_n  = {ICW2_T, lvl};
                end else if (cnt == GAP_LAST) begin
                    state_n = S_IDLE;
                    perr_n  = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_P2: begin
                if (rise) begin
                    state_n = S_IDLE;
                    doe_n   = 1'b0;
                    dout_n  = '0;
                    aeoi_n  = AEOI & valid;
                end
            end
            default: state_n = S_IDLE;
        endcase

        active_n = (state_n != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            inta_q          <= 1'b1;
            cnt             <= '0;
            lvl             <= '0;
            valid           <= 1'b0;
            own             <= 1'b0;
            icw3_q          <= '0;
            Data_Out        <= '0;
            Data_Out_Enable <= 1'b0;
            IS_Set          <= 1'b0;
            IS_Level        <= '0;
            Auto_EOI        <= 1'b0;
            Cycle_Active    <= 1'b0;
            Protocol_Error  <= 1'b0;
        end else begin
            state           <= state_n;
            inta_q          <= INTA_n;
            cnt             <= cnt_n;
            lvl             <= lvl_n;
            valid           <= valid_n;
            own             <= own_n;
            icw3_q          <= icw3_n;
            Data_Out        <= dout_n;
            Data_Out_Enable <= doe_n;
            IS_Set          <= is_set_n;
            IS_Level        <= is_level_n;
            Auto_EOI        <= aeoi_n;
            Cycle_Active    <= active_n;
            Protocol_Error  <= perr_n;
        end
    end

endmodule

// File: tb/tb_cascade_inta_responder.sv
// Scoreboard bench for cascade_inta_responder: each INTA sequence pushes its expected
// output events (kind, value, clock edge); a negedge monitor pops and compares them.
module tb_cascade_inta_responder;

    localparam int unsigned T = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       INTA_n = 1'b1;
    logic [2:0] CAS = '0;
    logic       SP = 1'b1;
    logic       SNGL = 1'b1;
    logic [7:0] ICW3 = '0;
    logic [4:0] ICW2_T = '0;
    logic       AEOI = 1'b0;
    logic [2:0] Interrupt_Location = '0;
    logic       interruptExists = 1'b0;
    logic [7:0] Data_Out;
    logic       Data_Out_Enable;
    logic       IS_Set;
    logic [2:0] IS_Level;
    logic       Auto_EOI;
    logic       Cycle_Active;
    logic       Protocol_Error;

    cascade_inta_responder #(.GAP_TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n), .INTA_n(INTA_n), .CAS(CAS), .SP(SP), .SNGL(SNGL),
        .ICW3(ICW3), .ICW2_T(ICW2_T), .AEOI(AEOI),
        .Interrupt_Location(Interrupt_Location), .interruptExists(interruptExists),
        .Data_Out(Data_Out), .Data_Out_Enable(Data_Out_Enable), .IS_Set(IS_Set),
        .IS_Level(IS_Level), .Auto_EOI(Auto_EOI), .Cycle_Active(Cycle_Active),
        .Protocol_Error(Protocol_Error)
    );

    always #5 clk = ~clk;

    int edge_no = 0;
    always @(posedge clk) edge_no <= edge_no + 1;

    // Event kinds, listed in the order the monitor reports same-edge events.
    localparam int K_CA_RISE = 0, K_IS_SET = 1, K_DRIVE = 2, K_DOE_FALL = 3,
                   K_AEOI = 4, K_PERR = 5, K_CA_FALL = 6;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    ev_t q[$];
    int  compared = 0;
    int  mismatched = 0;
    bit  mon_en = 1'b0;

    function automatic string kname(int k);
        case (k)
            K_CA_RISE:  return "cycle_active_rise";
            K_IS_SET:   return "is_set";
            K_DRIVE:    return "drive_vector";
            K_DOE_FALL: return "drive_release";
            K_AEOI:     return "auto_eoi";
            K_PERR:     return "protocol_error";
            K_CA_FALL:  return "cycle_active_fall";
            default:    return "unknown";
        endcase
    endfunction

    function automatic void push(int k, logic [7:0] d, int c);
        ev_t e;
        e.kind = k; e.data = d; e.cyc = c;
        q.push_back(e);
    endfunction

    function automatic void observe(int k, logic [7:0] d);
        ev_t e;
        compared++;
        if (q.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_%s: got data=%h at edge %0d, required no event",
                     kname(k), d, edge_no);
        end else begin
            e = q.pop_front();
            if (e.kind != k || e.data !== d || e.cyc != edge_no) begin
                mismatched++;
                $display("FAIL %s: got %s data=%h edge=%0d, required %s data=%h edge=%0d",
                         kname(e.kind), kname(k), d, edge_no, kname(e.kind), e.data, e.cyc);
            end
        end
    endfunction

    logic       prev_ca = 1'b0, prev_doe = 1'b0;
    logic [7:0] held = '0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (!prev_ca && Cycle_Active) observe(K_CA_RISE, 8'h00);
            if (IS_Set) observe(K_IS_SET, {5'b0, IS_Level});
            if (!prev_doe && Data_Out_Enable) begin
                observe(K_DRIVE, Data_Out);
                held = Data_Out;
            end else if (prev_doe && Data_Out_Enable) begin
                compared++;
                if (Data_Out !== held) begin
                    mismatched++;
                    $display("FAIL data_stable: got %h at edge %0d, required %h",
                             Data_Out, edge_no, held);
                end
            end
            if (prev_doe && !Data_Out_Enable) observe(K_DOE_FALL, 8'h00);
            if (Auto_EOI) observe(K_AEOI, {5'b0, IS_Level});
            if (Protocol_Error) observe(K_PERR, 8'h00);
            if (prev_ca && !Cycle_Active) observe(K_CA_FALL, 8'h00);
        end
        prev_ca  = Cycle_Active;
        prev_doe = Data_Out_Enable;
    end

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(string tag);
        chk({tag, "_data_out"}, Data_Out, 8'h00);
        chk({tag, "_doe"}, {7'b0, Data_Out_Enable}, 8'h00);
        chk({tag, "_is_set"}, {7'b0, IS_Set}, 8'h00);
        chk({tag, "_is_level"}, {5'b0, IS_Level}, 8'h00);
        chk({tag, "_auto_eoi"}, {7'b0, Auto_EOI}, 8'h00);
        chk({tag, "_cycle_active"}, {7'b0, Cycle_Active}, 8'h00);
        chk({tag, "_protocol_error"}, {7'b0, Protocol_Error}, 8'h00);
    endtask

    // Present INTA_n for the next sampling edge, then wait for the following negedge.
    task automatic drive(logic v);
        INTA_n = v;
        @(negedge clk);
    endtask

    // One acknowledge: w1 low, g high (including the rise edge), w2 low, tail high.
    // g > T means the gap times out and pulse 2 is never driven.
    // reset_in_p2 drops rst_n after two low edges of pulse 2 (requires w2 >= 3).
    task automatic run_seq(logic sngl, logic sp, logic [7:0] icw3, logic [4:0] t,
                           logic aeoi, logic [2:0] loc, logic exists, logic [2:0] cas,
                           int w1, int g, int w2, int tail, bit reset_in_p2);
        int         f, r1, f2, r2, rs;
        logic [2:0] lvl;
        logic       own;
        SNGL = sngl; SP = sp; ICW3 = icw3; ICW2_T = t; AEOI = aeoi;
        Interrupt_Location = loc; interruptExists = exists; CAS = cas;

        lvl = exists ? loc : 3'd7;
        own = sngl ? 1'b1 : (sp ? ~icw3[lvl] : (cas == icw3[2:0]));
        f  = edge_no + 1;
        r1 = f + w1;
        f2 = r1 + g;
        r2 = f2 + w2;

        push(K_CA_RISE, 8'h00, f);
        if (exists) push(K_IS_SET, {5'b0, lvl}, r1);
        if (g > int'(T)) begin
            push(K_PERR, 8'h00, r1 + int'(T));
            push(K_CA_FALL, 8'h00, r1 + int'(T));
        end else if (reset_in_p2) begin
            rs = f2 + 2;
            if (own) begin
                push(K_DRIVE, {t, lvl}, f2);
                push(K_DOE_FALL, 8'h00, rs);
            end
            push(K_CA_FALL, 8'h00, rs);
        end else begin
            if (own) begin
                push(K_DRIVE, {t, lvl}, f2);
                push(K_DOE_FALL, 8'h00, r2);
            end
            if (aeoi && exists) push(K_AEOI, {5'b0, lvl}, r2);
            push(K_CA_FALL, 8'h00, r2);
        end

        drive(1'b0);
        // Pending-request inputs may wander once the level has been latched.
        Interrupt_Location = 3'($urandom_range(0, 7));
        interruptExists = 1'($urandom_range(0, 1));
        for (int i = 1; i < w1; i++) drive(1'b0);
        for (int i = 0; i < g; i++) drive(1'b1);
        if (g <= int'(T)) begin
            if (reset_in_p2) begin
                drive(1'b0);
                drive(1'b0);
                rst_n = 1'b0;
                INTA_n = 1'b1;
                @(negedge clk);
                check_all_zero("reset_in_p2");
                rst_n = 1'b1;
                @(negedge clk);
            end else begin
                for (int i = 0; i < w2; i++) drive(1'b0);
                for (int i = 0; i < tail; i++) drive(1'b1);
            end
        end
    endtask

    initial begin
        int g;
        int r;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        // Single mode, level 3, base 01000 -> 8'h43
        run_seq(1, 1, 8'h00, 5'b01000, 0, 3'd3, 1, 3'd0, 2, 2, 2, 2, 0);
        // Master with slave on IR2: cascaded level owns nothing, level 5 is driven
        run_seq(0, 1, 8'h04, 5'b01000, 0, 3'd2, 1, 3'd0, 1, 3, 2, 1, 0);
        run_seq(0, 1, 8'h04, 5'b01000, 0, 3'd5, 1, 3'd0, 1, 3, 2, 1, 0);
        // Slave ID 2: matching / non-matching CAS
        run_seq(0, 0, 8'h02, 5'b10000, 0, 3'd6, 1, 3'd2, 2, 1, 1, 2, 0);
        run_seq(0, 0, 8'h02, 5'b10000, 0, 3'd6, 1, 3'd3, 2, 1, 1, 2, 0);
        // Spurious with AEOI, then real request with AEOI
        run_seq(1, 1, 8'h00, 5'b00110, 1, 3'd2, 0, 3'd0, 1, 2, 1, 1, 0);
        run_seq(1, 1, 8'h00, 5'b00110, 1, 3'd2, 1, 3'd0, 1, 2, 1, 1, 0);
        // Gap exactly at the limit, then one past it followed at once by a new first pulse
        run_seq(1, 1, 8'h00, 5'b11111, 1, 3'd4, 1, 3'd0, 1, T, 1, 1, 0);
        run_seq(1, 1, 8'h00, 5'b11111, 1, 3'd4, 1, 3'd0, 1, T + 1, 1, 1, 0);
        run_seq(0, 1, 8'h00, 5'b10101, 1, 3'd1, 1, 3'd0, 1, 1, 1, 1, 0);
        // Reset while the vector is driven, AEOI armed
        run_seq(1, 1, 8'h00, 5'b01010, 1, 3'd5, 1, 3'd0, 1, 2, 4, 1, 1);

        for (int n = 0; n < 60; n++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) g = T + 1;
            else if (r == 1) g = T;
            else g = int'($urandom_range(1, 4));
            run_seq(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                    5'($urandom), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                    int'($urandom_range(1, 3)), g, int'($urandom_range(1, 3)),
                    int'($urandom_range(1, 3)), 0);
        end

        repeat (4) @(negedge clk);
        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL missing_events: got %0d left in queue, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
